// File: rtl/rails_seq_feeder.sv
// Upstream stage of the rails stack-sequence checker: buffers and screens one size-prefixed
// nibble frame from the host, streams it to the checker, and tallies the checker's verdicts.
module rails_seq_feeder #(
    parameter int MAX_N   = 10,
    parameter int CNT_W   = 8,
    parameter int TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [3:0]       in_data,
    output logic             in_ready,
    output logic [3:0]       out_data,
    input  logic             chk_valid,
    input  logic             chk_result,
    output logic             busy,
    output logic [CNT_W-1:0] pass_cnt,
    output logic [CNT_W-1:0] fail_cnt,
    output logic [CNT_W-1:0] err_cnt
);

    localparam int         TMR_W  = $clog2(TIMEOUT + 1);
    localparam logic [3:0] MAX_N4 = 4'(MAX_N);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_DROP,
        S_SEND,
        S_WAIT
    } state_t;

    state_t           state;
    logic [3:0]       n;
    logic [3:0]       idx;
    logic [3:0]       remain;
    logic [3:0]       send_idx;
    logic [TMR_W-1:0] timer;
    logic             bad;
    logic [15:0]      bitmap;
    logic [3:0]       buf_q [MAX_N];

    logic accept;
    logic size_ok;
    logic entry_bad;

    assign accept    = in_valid & in_ready;
    assign size_ok   = (in_data >= 4'd3) && (in_data <= MAX_N4);
    // An entry is bad if it is outside 1..N or repeats a train already seen in this frame.
    assign entry_bad = (in_data == 4'd0) || (in_data > n) || bitmap[in_data];

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // NOTE: all state here is sequential, so every assignment is non-blocking; where two
    // assignments hit the same register in one cycle, the later one in program order wins.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= S_IDLE;
            in_ready <= 1'b1;
            busy     <= 1'b0;
            out_data <= '0;
            pass_cnt <= '0;
            fail_cnt <= '0;
            err_cnt  <= '0;
            n        <= '0;
            idx      <= '0;
            remain   <= '0;
            send_idx <= '0;
            timer    <= '0;
            bad      <= 1'b0;
            bitmap   <= '0;
            // NOTE: the frame buffer is small and must read back as zero after reset, so it
            // is reset here like any other register rather than left to power-up contents.
            for (int i = 0; i < MAX_N; i++) buf_q[i] <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        n <= in_data;
                        if (in_data == 4'd0) begin
                            err_cnt <= sat_inc(err_cnt);
                        end else if (size_ok) begin
                            state <= S_LOAD;
                            busy  <= 1'b1;
                        end else begin
                            state  <= S_DROP;
                            remain <= in_data;
                            busy   <= 1'b1;
                        end
                    end
                end

                S_LOAD: begin
                    if (accept) begin
                        buf_q[idx]      <= in_data;
                        bitmap[in_data] <= 1'b1;
                        if (entry_bad) bad <= 1'b1;
                        if (idx == n - 4'd1) begin
                            if (bad || entry_bad) begin
                                state   <= S_IDLE;
                                busy    <= 1'b0;
                                err_cnt <= sat_inc(err_cnt);
                                bitmap  <= '0;
                                idx     <= '0;
                                bad     <= 1'b0;
                            end else begin
                                state    <= S_SEND;
                                in_ready <= 1'b0;
                                out_data <= n;
                                send_idx <= '0;
                            end
                        end else begin
                            idx <= idx + 4'd1;
                        end
                    end
                end

                S_DROP: begin
                    if (accept) begin
                        if (remain == 4'd1) begin
                            state   <= S_IDLE;
                            busy    <= 1'b0;
                            err_cnt <= sat_inc(err_cnt);
                            bitmap  <= '0;
                            idx     <= '0;
                            bad     <= 1'b0;
                        end else begin
                            remain <= remain - 4'd1;
                        end
                    end
                end

                S_SEND: begin
                    if (send_idx < n) begin
                        out_data <= buf_q[send_idx];
                        send_idx <= send_idx + 4'd1;
                    end else begin
                        out_data <= '0;
                        state    <= S_WAIT;
                        timer    <= '0;
                    end
                end

                S_WAIT: begin
                    // A verdict on the final timer cycle still counts as a verdict.
                    if (chk_valid || timer == TMR_W'(TIMEOUT - 1)) begin
                        if (!chk_valid)     err_cnt  <= sat_inc(err_cnt);
                        else if (chk_result) pass_cnt <= sat_inc(pass_cnt);
                        else                fail_cnt <= sat_inc(fail_cnt);
                        state    <= S_IDLE;
                        in_ready <= 1'b1;
                        busy     <= 1'b0;
                        bitmap   <= '0;
                        idx      <= '0;
                        bad      <= 1'b0;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end

                default: begin
                    state    <= S_IDLE;
                    in_ready <= 1'b1;
                    busy     <= 1'b0;
                    out_data <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rails_seq_feeder.sv
// Directed self-checking bench for rails_seq_feeder: host frames, streamed output,
// checker verdicts, malformed-frame drops, WAIT timeout and mid-frame reset.
module tb_rails_seq_feeder;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       in_valid = 1'b0;
    logic [3:0] in_data = '0;
    logic       chk_valid = 1'b0;
    logic       chk_result = 1'b0;
    logic       in_ready;
    logic [3:0] out_data;
    logic       busy;
    logic [7:0] pass_cnt;
    logic [7:0] fail_cnt;
    logic [7:0] err_cnt;

    int checks = 0;
    int errors = 0;
    int exp_pass = 0;
    int exp_fail = 0;
    int exp_err = 0;

    rails_seq_feeder #(
        .MAX_N  (10),
        .CNT_W  (8),
        .TIMEOUT(64)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .chk_valid (chk_valid),
        .chk_result(chk_result),
        .busy      (busy),
        .pass_cnt  (pass_cnt),
        .fail_cnt  (fail_cnt),
        .err_cnt   (err_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_counts(input string tag);
        check({tag, "_pass"}, 32'(pass_cnt), 32'(exp_pass));
        check({tag, "_fail"}, 32'(fail_cnt), 32'(exp_fail));
        check({tag, "_err"},  32'(err_cnt),  32'(exp_err));
    endtask

    // Present one nibble and hold it until the feeder takes it (bounded wait).
    task automatic push(input logic [3:0] d);
        int waited = 0;
        in_valid = 1'b1;
        in_data  = d;
        while (!in_ready && waited < 100) begin
            tick();
            waited++;
        end
        if (!in_ready) check("push_ready", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        in_data  = '0;
    endtask

    // Words are written left to right in the hex constant: first nibble is most significant.
    task automatic push_frame(input int len, input logic [63:0] words, input int gap);
        for (int i = 0; i < len; i++) begin
            if (i > 0) repeat (gap) tick();
            push(words[4*(len-1-i) +: 4]);
        end
    endtask

    // Called right after the last entry is taken: expects N then the entries, no gaps.
    task automatic check_stream(input int len, input logic [63:0] words);
        for (int i = 0; i < len; i++) begin
            if (i > 0) tick();
            check($sformatf("stream%0d", i), 32'(out_data), 32'(words[4*(len-1-i) +: 4]));
        end
        tick();
        check("stream_end_data", 32'(out_data), 32'd0);
        check("stream_end_busy", 32'(busy), 32'd1);
        check("stream_end_rdy",  32'(in_ready), 32'd0);
    endtask

    task automatic verdict(input logic res);
        chk_valid  = 1'b1;
        chk_result = res;
        tick();
        chk_valid  = 1'b0;
        chk_result = 1'b0;
        if (res) exp_pass++;
        else     exp_fail++;
        check("verdict_busy", 32'(busy), 32'd0);
        check("verdict_rdy",  32'(in_ready), 32'd1);
        check_counts("verdict");
    endtask

    initial begin
        int k;

        // Reset state
        repeat (2) tick();
        check("rst_rdy",  32'(in_ready), 32'd1);
        check("rst_data", 32'(out_data), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check_counts("rst");
        reset = 1'b1;
        tick();

        // T1: judged unrealisable
        push_frame(7, 64'h6241365, 0);
        check_stream(7, 64'h6241365);
        verdict(1'b0);

        // T2: judged realisable
        push_frame(6, 64'h543251, 0);
        check_stream(6, 64'h543251);
        verdict(1'b1);

        // T3: duplicate entry is dropped without streaming, then a good frame goes out
        push_frame(5, 64'h41223, 0);
        exp_err++;
        for (int i = 0; i < 3; i++) begin
            check("dup_quiet_data", 32'(out_data), 32'd0);
            tick();
        end
        check("dup_busy", 32'(busy), 32'd0);
        check_counts("dup");
        push_frame(4, 64'h3312, 0);
        check_stream(4, 64'h3312);
        verdict(1'b1);

        // Entry larger than N
        push_frame(4, 64'h3152, 0);
        exp_err++;
        tick();
        check("big_busy", 32'(busy), 32'd0);
        check_counts("big");

        // T4: oversize frame fully consumed, size 0 consumes nothing, size 2 drops 2 words
        push_frame(13, 64'hC123456789ABC, 0);
        exp_err++;
        check("drop_busy", 32'(busy), 32'd0);
        check("drop_rdy",  32'(in_ready), 32'd1);
        check_counts("drop");
        push(4'd0);
        exp_err++;
        check("zero_busy", 32'(busy), 32'd0);
        check_counts("zero");
        push_frame(3, 64'h2FF, 0);
        exp_err++;
        check("small_busy", 32'(busy), 32'd0);
        check_counts("small");
        push_frame(4, 64'h3231, 0);
        check_stream(4, 64'h3231);
        verdict(1'b0);

        // T5: strobes during SEND are ignored; silence in WAIT times out after 64 cycles
        push_frame(4, 64'h3123, 0);
        chk_valid  = 1'b1;
        chk_result = 1'b1;
        check_stream(4, 64'h3123);
        chk_valid  = 1'b0;
        chk_result = 1'b0;
        check_counts("send_ignore");
        k = 0;
        while (32'(err_cnt) == 32'(exp_err) && k < 200) begin
            tick();
            k++;
        end
        exp_err++;
        check("timeout_cycles", 32'(k), 32'd64);
        check("timeout_rdy",  32'(in_ready), 32'd1);
        check("timeout_busy", 32'(busy), 32'd0);
        check_counts("timeout");

        // T6: gapped load, then reset mid-SEND
        push_frame(5, 64'h44321, 2);
        check("gap_size", 32'(out_data), 32'd4);
        tick();
        check("gap_first", 32'(out_data), 32'd4);
        #2;
        reset = 1'b0;
        #1;
        exp_pass = 0;
        exp_fail = 0;
        exp_err  = 0;
        check("abort_data", 32'(out_data), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_rdy",  32'(in_ready), 32'd1);
        check_counts("abort");
        tick();
        reset = 1'b1;
        tick();
        push_frame(4, 64'h3213, 0);
        check_stream(4, 64'h3213);
        verdict(1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
